// File: rtl/fifo_write_drainer.sv
// rtl/fifo_write_drainer.sv - drains a write-request FIFO into a stallable byte-write memory port
module fifo_write_drainer #(
  parameter int ADDR_BITS  = 17,
  parameter int BYTE_BITS  = 8,
  parameter int DATA_WIDTH = 25,
  parameter int MAX_BURST  = 16,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [BYTE_BITS-1:0]  mem_data,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   write_count
);

  localparam int BURST_BITS = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_POP    = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [BYTE_BITS-1:0]  data_q, data_d;
  logic [BURST_BITS-1:0] burst_q, burst_d;
  logic [BURST_BITS-1:0] burst_inc;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  we_q, rd_en_q, busy_q;

  assign burst_inc = burst_q + BURST_BITS'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    burst_d = burst_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        burst_d = '0;
        if (enable && !fifo_empty) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_POP;
      S_POP: begin
        addr_d  = fifo_rd_data[DATA_WIDTH-1:BYTE_BITS];
        data_d  = fifo_rd_data[BYTE_BITS-1:0];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          count_d = count_q + CNT_BITS'(1);
          burst_d = burst_inc;
          // A full burst always returns to IDLE so the arbiter sees a free cycle.
          if (burst_inc == BURST_BITS'(MAX_BURST)) state_d = S_IDLE;
          else if (!fifo_empty && enable)          state_d = S_SETTLE;
          else                                     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      burst_q <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      burst_q <= burst_d;
      count_q <= count_d;
      we_q    <= (state_d == S_WRITE);
      rd_en_q <= (state_d == S_POP);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_we      = we_q;
  assign busy        = busy_q;
  assign write_count = count_q;

endmodule

// File: tb/tb_fifo_write_drainer.sv
// tb/tb_fifo_write_drainer.sv - scoreboard bench for fifo_write_drainer with a behavioural FIFO
module tb_fifo_write_drainer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [24:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic [3:0]  write_count;

  logic        push_en = 1'b0;
  logic [24:0] push_data = '0;

  logic [24:0] fq[$];
  logic [24:0] exp_q[$];
  int          wr_cyc[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          rd_pulses = 0;
  logic [3:0]  model_cnt = '0;
  bit          cnt_pending = 1'b0;

  fifo_write_drainer #(
    .ADDR_BITS(17), .BYTE_BITS(8), .DATA_WIDTH(25), .MAX_BURST(4), .CNT_BITS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered-output FIFO: flag and head data update on the same edge as the pointers.
  always @(posedge clk) begin
    cyc++;
    if (push_en) fq.push_back(push_data);
    if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
    fifo_empty   <= (fq.size() == 0);
    fifo_rd_data <= (fq.size() > 0) ? fq[0] : '0;
  end

  always @(negedge clk) begin
    logic [24:0] e;
    if (cnt_pending) begin
      chk("write_count", 64'(write_count), 64'(model_cnt));
      cnt_pending = 1'b0;
    end
    if (reset_n && mem_we && mem_ready) begin
      if (exp_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e[24:8]));
        chk("mem_data", 64'(mem_data), 64'(e[7:0]));
      end
      wr_cyc.push_back(cyc);
      n_writes++;
      model_cnt = model_cnt + 4'd1;
      cnt_pending = 1'b1;
    end
    if (fifo_rd_en) begin
      rd_pulses++;
      chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [24:0] d);
    push_en   = 1'b1;
    push_data = d;
    exp_q.push_back(d);
    step();
    push_en = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 400 && n_writes < target; i++) step();
    if (n_writes < target) chk("timeout_writes", 64'(n_writes), 64'(target));
    step();
    step();
  endtask

  task automatic wait_we();
    int i;
    for (i = 0; i < 40 && !mem_we; i++) step();
    if (!mem_we) chk("timeout_mem_we", 64'd0, 64'd1);
  endtask

  initial begin
    int base, rd0;

    #12;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(write_count), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
    step();

    // Single entry: cycle-exact latency from the push edge.
    push(25'h1ABCD5A);
    chk("e1_empty", 64'(fifo_empty), 64'd0);
    chk("e1_busy", 64'(busy), 64'd0);
    step();
    chk("e2_busy", 64'(busy), 64'd1);
    chk("e2_rd_en", 64'(fifo_rd_en), 64'd0);
    step();
    chk("e3_rd_en", 64'(fifo_rd_en), 64'd1);
    chk("e3_we", 64'(mem_we), 64'd0);
    step();
    chk("e4_we", 64'(mem_we), 64'd1);
    chk("e4_addr", 64'(mem_addr), 64'h1ABCD);
    chk("e4_data", 64'(mem_data), 64'h5A);
    chk("e4_rd_en", 64'(fifo_rd_en), 64'd0);
    step();
    chk("e5_busy", 64'(busy), 64'd0);
    chk("e5_we", 64'(mem_we), 64'd0);
    chk("e5_count", 64'(write_count), 64'd1);

    // Back-pressure: ready low for five WRITE cycles.
    mem_ready = 1'b0;
    rd0  = rd_pulses;
    base = n_writes;
    push(25'h0F00F3C);
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_we_held", 64'(mem_we), 64'd1);
      chk("bp_addr_held", 64'(mem_addr), 64'h0F00F);
      chk("bp_data_held", 64'(mem_data), 64'h3C);
      step();
    end
    chk("bp_we_6th", 64'(mem_we), 64'd1);
    mem_ready = 1'b1;
    step();
    chk("bp_we_drop", 64'(mem_we), 64'd0);
    chk("bp_one_pop", 64'(rd_pulses - rd0), 64'd1);
    chk("bp_one_write", 64'(n_writes - base), 64'd1);
    step();

    // Burst of 6 with MAX_BURST=4: one extra idle cycle after the 4th write.
    wr_cyc.delete();
    base = n_writes;
    push_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_data = {17'(17'h10000 + i), 8'(8'h80 + i)};
      exp_q.push_back(push_data);
      step();
    end
    push_en = 1'b0;
    wait_writes(base + 6);
    if (wr_cyc.size() == 6) begin
      chk("gap_1_2", 64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
      chk("gap_2_3", 64'(wr_cyc[2] - wr_cyc[1]), 64'd3);
      chk("gap_3_4", 64'(wr_cyc[3] - wr_cyc[2]), 64'd3);
      chk("gap_yield", 64'(wr_cyc[4] - wr_cyc[3]), 64'd4);
      chk("gap_5_6", 64'(wr_cyc[5] - wr_cyc[4]), 64'd3);
    end else chk("burst_write_total", 64'(wr_cyc.size()), 64'd6);
    chk("burst_count", 64'(write_count), 64'd8);

    // Enable dropped during the first WRITE: only that entry goes out.
    base = n_writes;
    rd0  = rd_pulses;
    push(25'h00111_11);
    push(25'h00222_22);
    push(25'h00333_33);
    wait_we();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("gate_one_write", 64'(n_writes - base), 64'd1);
    chk("gate_one_pop", 64'(rd_pulses - rd0), 64'd1);
    chk("gate_fifo_left", 64'(fq.size()), 64'd2);
    chk("gate_idle", 64'(busy), 64'd0);
    enable = 1'b1;
    wait_writes(base + 3);
    chk("gate_fifo_drained", 64'(fq.size()), 64'd0);

    // Asynchronous reset while stalled in WRITE.
    mem_ready = 1'b0;
    push(25'h15555_AA);
    wait_we();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 64'(mem_we), 64'd0);
    chk("arst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_count", 64'(write_count), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_cnt   = '0;
    cnt_pending = 1'b0;
    step();
    step();
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    step();
    base = n_writes;
    push(25'h0ABCD_77);
    wait_writes(base + 1);
    chk("post_rst_count", 64'(write_count), 64'd1);

    // 17 more writes wrap the 4-bit counter through 15, 0, 1.
    base = n_writes;
    push_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_data = {17'(17'h02000 + 3 * i), 8'($urandom_range(0, 255))};
      exp_q.push_back(push_data);
      step();
    end
    push_en = 1'b0;
    wait_writes(base + 17);
    chk("wrap_final", 64'(write_count), 64'd2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
